relu_pool_scheduler: RTL and testbench

// - Sequences the convolution engine and ReLU/max-pool unit for one layer pass after dut_run.
// - Issues conv output coordinates in 2x2 pooling-window order, filter outer, so the pool unit's 4-count groups align with windows.
// - Drives the pool unit's valid_in codes and writes each pooled byte to the output SRAM.
// - Signals completion with a single-cycle dut_done pulse.

---
 rtl/relu_pool_scheduler_pkg.sv | 35 +++
 rtl/relu_pool_scheduler_if.sv | 44 ++++
 rtl/relu_pool_scheduler_pool_scan_counter.sv | 79 +++++++
 rtl/relu_pool_scheduler.sv | 168 ++++++++++++++++
 tb/tb_relu_pool_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/relu_pool_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// cnn_ctrl_pkg
// Shared definitions for the ReLU/max-pool scheduler slice:
//   - pool unit valid_in / valid_out codes
//   - scheduler FSM state encoding
//   - helpers that derive the pooled side and a safe counter width
// ---------------------------------------------------------------------------
package cnn_ctrl_pkg;

  // Codes on the pool unit's valid_in / valid_out buses
  localparam logic [1:0] VLD_NONE = 2'd0;
  localparam logic [1:0] VLD_F0   = 2'd1;
  localparam logic [1:0] VLD_F1   = 2'd2;
  localparam logic [1:0] VLD_LAST = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } sched_state_e;

  // Pooled side for a valid (unpadded) convolution followed by 2x2 pooling
  function automatic int pool_size(input int img_dim, input int kernel);
    return (img_dim - kernel + 1) / 2;
  endfunction

  // Counter width that never collapses to zero bits for a range of 1
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/relu_pool_scheduler_if.sv
// ---------------------------------------------------------------------------
// relu_pool_scheduler_if
// Bundles every non-clock/reset signal of the scheduler.
//   master : the scheduler itself (drives control, conv, pool and SRAM side)
//   slave  : the environment (host start, conv engine, pool unit, SRAM)
// Signals:
//   dut_run / dut_busy / dut_done    host start and status
//   conv_req / conv_row / conv_col / conv_filter / conv_done   conv engine
//   pool_valid_in / pool_valid_out / pool_data                pool unit
//   sram_we / sram_addr / sram_wdata                           output SRAM
//   protocol_err                                              sticky error
// ---------------------------------------------------------------------------
interface relu_pool_scheduler_if #(
  parameter int CONV_W = 2,
  parameter int ADDR_W = 8
);
  logic              dut_run;
  logic              dut_busy;
  logic              dut_done;
  logic              conv_req;
  logic [CONV_W-1:0] conv_row;
  logic [CONV_W-1:0] conv_col;
  logic              conv_filter;
  logic              conv_done;
  logic [1:0]        pool_valid_in;
  logic [1:0]        pool_valid_out;
  logic [7:0]        pool_data;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_wdata;
  logic              protocol_err;

  modport master (
    input  dut_run, conv_done, pool_valid_out, pool_data,
    output dut_busy, dut_done, conv_req, conv_row, conv_col, conv_filter,
           pool_valid_in, sram_we, sram_addr, sram_wdata, protocol_err
  );

  modport slave (
    output dut_run, conv_done, pool_valid_out, pool_data,
    input  dut_busy, dut_done, conv_req, conv_row, conv_col, conv_filter,
           pool_valid_in, sram_we, sram_addr, sram_wdata, protocol_err
  );
endinterface

// File: rtl/relu_pool_scheduler_pool_scan_counter.sv
// ---------------------------------------------------------------------------
// pool_scan_counter
// Nested scan counter, outer to inner: filter f, pool row pr, pool col pc,
// quadrant q. Each stage wraps at its maximum and carries outward, so conv
// coordinates come out in 2x2 pooling-window order with filter outermost.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   clear_i         synchronous return to the first coordinate
//   advance_i       step to the next coordinate
//   row_o, col_o    conv output coordinate (2*pr + q[1], 2*pc + q[0])
//   filter_o, q_o   current filter and quadrant
//   last_window_o   high on the final coordinate of the whole pass
// ---------------------------------------------------------------------------
module pool_scan_counter
  import cnn_ctrl_pkg::*;
#(
  parameter int POOL_DIM = 2,
  parameter int POOL_W   = 1,
  parameter int CONV_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [CONV_W-1:0] row_o,
  output logic [CONV_W-1:0] col_o,
  output logic              filter_o,
  output logic [1:0]        q_o,
  output logic              last_window_o
);

  localparam logic [POOL_W-1:0] POOL_MAX = POOL_W'(POOL_DIM - 1);

  logic [1:0]        q_q;
  logic [POOL_W-1:0] pc_q;
  logic [POOL_W-1:0] pr_q;
  logic              f_q;
  logic              q_wrap;
  logic              pc_wrap;
  logic              pr_wrap;

  assign q_wrap  = (q_q == 2'd3);
  assign pc_wrap = (pc_q == POOL_MAX);
  assign pr_wrap = (pr_q == POOL_MAX);

  // Ripple-carry style nest: an inner wrap is what lets the next stage move
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q  <= '0;
      pc_q <= '0;
      pr_q <= '0;
      f_q  <= 1'b0;
    end else if (clear_i) begin
      q_q  <= '0;
      pc_q <= '0;
      pr_q <= '0;
      f_q  <= 1'b0;
    end else if (advance_i) begin
      q_q <= q_q + 2'd1;
      if (q_wrap) begin
        pc_q <= pc_wrap ? '0 : pc_q + 1'b1;
        if (pc_wrap) begin
          pr_q <= pr_wrap ? '0 : pr_q + 1'b1;
          if (pr_wrap) begin
            f_q <= ~f_q;
          end
        end
      end
    end
  end

  // Concatenation is exactly 2*p + quadrant bit
  assign row_o         = CONV_W'({pr_q, q_q[1]});
  assign col_o         = CONV_W'({pc_q, q_q[0]});
  assign filter_o      = f_q;
  assign q_o           = q_q;
  assign last_window_o = f_q & pr_wrap & pc_wrap & q_wrap;

endmodule

// File: rtl/relu_pool_scheduler.sv
// ---------------------------------------------------------------------------
// relu_pool_scheduler
// Runs one layer pass: requests every conv output in 2x2 pooling-window
// order (filter outermost), feeds the pool unit its valid codes, writes each
// pooled byte to the output SRAM and pulses dut_done at the end.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   bus          relu_pool_scheduler_if.master (host, conv, pool, SRAM,
//                protocol_err)
// Parameters: IMG_DIM, KERNEL, POOL_DIM (derived, do not override), ADDR_W.
// ---------------------------------------------------------------------------
module relu_pool_scheduler
  import cnn_ctrl_pkg::*;
#(
  parameter int IMG_DIM  = 16,
  parameter int KERNEL   = 3,
  parameter int POOL_DIM = pool_size(IMG_DIM, KERNEL),
  parameter int ADDR_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  relu_pool_scheduler_if.master  bus
);

  localparam int CONV_DIM = IMG_DIM - KERNEL + 1;
  localparam int CONV_W   = width_of(CONV_DIM);
  localparam int POOL_W   = width_of(POOL_DIM);

  sched_state_e      state_q;
  logic              busy_q;
  logic              done_q;
  logic              conv_req_q;
  logic [1:0]        vin_q;
  logic              pend_q;
  logic              pend_filter_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              err_q;

  logic              cnt_clear;
  logic              cnt_advance;
  logic [CONV_W-1:0] scan_row;
  logic [CONV_W-1:0] scan_col;
  logic              scan_filter;
  logic [1:0]        scan_q;
  logic              scan_last;
  logic [ADDR_W-1:0] win_addr;
  logic              vout_data;
  logic              wr_fire;
  logic              err_set;

  assign cnt_clear   = (state_q == IDLE) && bus.dut_run;
  assign cnt_advance = (state_q == WAIT) && bus.conv_done;

  pool_scan_counter #(
    .POOL_DIM (POOL_DIM),
    .POOL_W   (POOL_W),
    .CONV_W   (CONV_W)
  ) u_scan (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (cnt_clear),
    .advance_i     (cnt_advance),
    .row_o         (scan_row),
    .col_o         (scan_col),
    .filter_o      (scan_filter),
    .q_o           (scan_q),
    .last_window_o (scan_last)
  );

  // Pool coordinates are the conv coordinates with the quadrant bit dropped
  assign win_addr = ADDR_W'(scan_filter) * ADDR_W'(POOL_DIM * POOL_DIM)
                  + ADDR_W'(scan_row >> 1) * ADDR_W'(POOL_DIM)
                  + ADDR_W'(scan_col >> 1);

  // Sequencer; every host/conv/pool-facing control output is a register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conv_req_q <= 1'b0;
      vin_q      <= VLD_NONE;
    end else begin
      conv_req_q <= 1'b0;
      done_q     <= 1'b0;
      vin_q      <= VLD_NONE;
      case (state_q)
        IDLE: begin
          if (bus.dut_run) begin
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          conv_req_q <= 1'b1;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (bus.conv_done) begin
            vin_q   <= scan_filter ? VLD_F1 : VLD_F0;
            state_q <= scan_last ? FLUSH : ISSUE;
          end
        end
        FLUSH: begin
          vin_q   <= VLD_LAST;
          state_q <= DRAIN;
        end
        DRAIN: begin
          if (bus.pool_valid_out == VLD_LAST) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A pooled byte may only be written for a window whose 4th conv completed
  assign vout_data = (bus.pool_valid_out == VLD_F0) || (bus.pool_valid_out == VLD_F1);
  assign wr_fire   = vout_data && pend_q;

  assign err_set = (vout_data && !pend_q)
                 || (bus.conv_done && (state_q != WAIT))
                 || (wr_fire && (bus.pool_valid_out != (pend_filter_q ? VLD_F1 : VLD_F0)));

  // Pending-window latch and sticky error; a new latch wins over a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q        <= 1'b0;
      pend_filter_q <= 1'b0;
      wr_addr_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      if (wr_fire) begin
        pend_q <= 1'b0;
      end
      if (cnt_advance && (scan_q == 2'd3)) begin
        pend_q        <= 1'b1;
        pend_filter_q <= scan_filter;
        wr_addr_q     <= win_addr;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.dut_busy      = busy_q;
  assign bus.dut_done      = done_q;
  assign bus.conv_req      = conv_req_q;
  assign bus.conv_row      = scan_row;
  assign bus.conv_col      = scan_col;
  assign bus.conv_filter   = scan_filter;
  assign bus.pool_valid_in = vin_q;
  assign bus.protocol_err  = err_q;
  // Write data/address are gated so the bus reads zero whenever no write fires
  assign bus.sram_we       = wr_fire;
  assign bus.sram_addr     = wr_fire ? wr_addr_q : '0;
  assign bus.sram_wdata    = wr_fire ? bus.pool_data : '0;

endmodule

// File: tb/tb_relu_pool_scheduler.sv
// ---------------------------------------------------------------------------
// tb_relu_pool_scheduler
// Directed sequence around a conv-engine / pool-unit responder. Expected
// conv order, valid codes and SRAM writes come from nested loops over
// filter / pool row / pool col / quadrant.
// ---------------------------------------------------------------------------
module tb_relu_pool_scheduler;

  localparam int POOL = 2;
  localparam int NCONV = 2 * POOL * POOL * 4;
  localparam int NWIN = 2 * POOL * POOL;

  logic clk;
  logic reset;

  relu_pool_scheduler_if #(.CONV_W(2), .ADDR_W(8)) ifc();

  relu_pool_scheduler #(
    .IMG_DIM (6),
    .KERNEL  (3),
    .ADDR_W  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int   assertCount = 0;
  int   failCount = 0;
  int   cycleCnt = 0;
  int   doneCount = 0;
  int   convCnt = 0;
  int   grp = 0;
  int   winIdx = 0;
  bit   randomMode = 1'b0;
  bit   injectConvDone = 1'b0;
  bit   injectPool = 1'b0;
  logic [1:0] poolOutNext = 2'd0;
  logic [7:0] poolDataNext = 8'd0;
  int   convLog[$];
  int   vinLog[$];
  int   fourthCycle[$];
  int   expData[$];
  int   wrAddrLog[$];
  int   wrDataLog[$];
  int   wrCycleLog[$];

  // Responder: conv engine answers after a latency, pool unit emits one
  // result the cycle after each 4th valid and echoes LAST; then log outputs
  always @(negedge clk) begin
    logic       convFire;
    logic [1:0] vin;
    if (reset) begin
      convCnt = 0;
      grp = 0;
      winIdx = 0;
      poolOutNext = 2'd0;
      poolDataNext = 8'd0;
      ifc.conv_done = 1'b0;
      ifc.pool_valid_out = 2'd0;
      ifc.pool_data = 8'd0;
    end else begin
      cycleCnt++;
      convFire = 1'b0;
      if (convCnt > 0) begin
        convCnt--;
        if (convCnt == 0) convFire = 1'b1;
      end
      if (ifc.conv_req) begin
        convCnt = randomMode ? int'($urandom_range(4, 1)) : 2;
        convLog.push_back(int'(ifc.conv_filter) * 256 + int'(ifc.conv_row) * 16 + int'(ifc.conv_col));
      end
      ifc.conv_done = convFire | injectConvDone;
      ifc.pool_valid_out = injectPool ? 2'd1 : poolOutNext;
      ifc.pool_data = poolDataNext;
      poolOutNext = 2'd0;
      vin = ifc.pool_valid_in;
      if (vin != 2'd0) vinLog.push_back(int'(vin));
      if (vin == 2'd1 || vin == 2'd2) begin
        grp++;
        if (grp == 4) begin
          grp = 0;
          poolOutNext = vin;
          poolDataNext = randomMode ? 8'($urandom_range(127, 0)) : 8'(winIdx * 3);
          expData.push_back(int'(poolDataNext));
          fourthCycle.push_back(cycleCnt);
          winIdx++;
        end
      end else if (vin == 2'd3) begin
        poolOutNext = 2'd3;
      end
    end
    #3;
    if (!reset) begin
      if (ifc.sram_we) begin
        wrAddrLog.push_back(int'(ifc.sram_addr));
        wrDataLog.push_back(int'(ifc.sram_wdata));
        wrCycleLog.push_back(cycleCnt);
      end
      if (ifc.dut_done) doneCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic nextSample();
    @(negedge clk);
    #4;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) nextSample();
  endtask

  // One-cycle start pulse
  task automatic applyStimulus();
    ifc.dut_run = 1'b1;
    nextSample();
    ifc.dut_run = 1'b0;
  endtask

  task automatic waitDone(input int base, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      nextSample();
      if (doneCount > base) seen = 1'b1;
    end
  endtask

  task automatic waitConvReqs(input int target, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      nextSample();
      if (convLog.size() >= target) seen = 1'b1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(ifc.dut_busy), 0);
    checkOutput({tag, "_done"}, 32'(ifc.dut_done), 0);
    checkOutput({tag, "_req"}, 32'(ifc.conv_req), 0);
    checkOutput({tag, "_row"}, 32'(ifc.conv_row), 0);
    checkOutput({tag, "_col"}, 32'(ifc.conv_col), 0);
    checkOutput({tag, "_filt"}, 32'(ifc.conv_filter), 0);
    checkOutput({tag, "_vin"}, 32'(ifc.pool_valid_in), 0);
    checkOutput({tag, "_we"}, 32'(ifc.sram_we), 0);
    checkOutput({tag, "_addr"}, 32'(ifc.sram_addr), 0);
    checkOutput({tag, "_wdata"}, 32'(ifc.sram_wdata), 0);
    checkOutput({tag, "_err"}, 32'(ifc.protocol_err), 0);
  endtask

  // Reference model of one complete pass, compared against the logs
  task automatic checkPass(input string tag, input int bC, input int bV, input int bW, input int bF);
    int idx;
    int got;
    int expv;
    checkOutput({tag, "_nconv"}, 32'(convLog.size() - bC), NCONV);
    idx = 0;
    for (int f = 0; f < 2; f++)
      for (int pr = 0; pr < POOL; pr++)
        for (int pc = 0; pc < POOL; pc++)
          for (int q = 0; q < 4; q++) begin
            expv = f * 256 + (2 * pr + q / 2) * 16 + (2 * pc + q % 2);
            got = (bC + idx < convLog.size()) ? convLog[bC + idx] : -1;
            checkOutput($sformatf("%s_coord%0d", tag, idx), 32'(got), 32'(expv));
            idx++;
          end
    checkOutput({tag, "_nvin"}, 32'(vinLog.size() - bV), NCONV + 1);
    for (int i = 0; i <= NCONV; i++) begin
      expv = (i < NCONV / 2) ? 1 : ((i < NCONV) ? 2 : 3);
      got = (bV + i < vinLog.size()) ? vinLog[bV + i] : -1;
      checkOutput($sformatf("%s_vin%0d", tag, i), 32'(got), 32'(expv));
    end
    checkOutput({tag, "_nwr"}, 32'(wrAddrLog.size() - bW), NWIN);
    idx = 0;
    for (int f = 0; f < 2; f++)
      for (int pr = 0; pr < POOL; pr++)
        for (int pc = 0; pc < POOL; pc++) begin
          expv = f * POOL * POOL + pr * POOL + pc;
          got = (bW + idx < wrAddrLog.size()) ? wrAddrLog[bW + idx] : -1;
          checkOutput($sformatf("%s_addr%0d", tag, idx), 32'(got), 32'(expv));
          expv = (bF + idx < expData.size()) ? expData[bF + idx] : -2;
          got = (bW + idx < wrDataLog.size()) ? wrDataLog[bW + idx] : -1;
          checkOutput($sformatf("%s_data%0d", tag, idx), 32'(got), 32'(expv));
          got = (bW + idx < wrCycleLog.size() && bF + idx < fourthCycle.size())
                ? wrCycleLog[bW + idx] - fourthCycle[bF + idx] : -1;
          checkOutput($sformatf("%s_lat%0d", tag, idx), 32'(got), 1);
          idx++;
        end
  endtask

  initial begin
    int bC, bV, bW, bF, bD, nWr;
    bit seen;

    ifc.dut_run = 1'b0;
    reset = 1'b1;
    $display("[TB] reset");
    waitCycles(3);
    checkAllZero("rst");
    reset = 1'b0;
    nextSample();

    // Pass 1: fixed conv latency, pool data = window*3
    $display("[TB] directed pass");
    bC = convLog.size(); bV = vinLog.size(); bW = wrAddrLog.size();
    bF = fourthCycle.size(); bD = doneCount;
    applyStimulus();
    checkOutput("p1_busy", 32'(ifc.dut_busy), 1);
    waitDone(bD, 1000, seen);
    checkOutput("p1_doneSeen", 32'(seen), 1);
    checkOutput("p1_busyDrop", 32'(ifc.dut_busy), 0);
    nextSample();
    checkOutput("p1_donePulse", 32'(ifc.dut_done), 0);
    for (int w = 0; w < NWIN; w++)
      checkOutput($sformatf("p1_model%0d", w), 32'((bF + w < expData.size()) ? expData[bF + w] : -1), 32'(w * 3));
    checkPass("p1", bC, bV, bW, bF);
    checkOutput("p1_ndone", 32'(doneCount - bD), 1);
    checkOutput("p1_err", 32'(ifc.protocol_err), 0);

    // dut_run held for the whole pass gives exactly one pass
    $display("[TB] held-run pass");
    waitCycles(2);
    bC = convLog.size(); bV = vinLog.size(); bW = wrAddrLog.size();
    bF = fourthCycle.size(); bD = doneCount;
    ifc.dut_run = 1'b1;
    waitDone(bD, 1000, seen);
    ifc.dut_run = 1'b0;
    checkOutput("hold_doneSeen", 32'(seen), 1);
    waitCycles(20);
    checkPass("hold", bC, bV, bW, bF);
    checkOutput("hold_ndone", 32'(doneCount - bD), 1);
    checkOutput("hold_idle", 32'(ifc.dut_busy), 0);

    // Randomised conv latency and pool data
    $display("[TB] random pass");
    randomMode = 1'b1;
    bC = convLog.size(); bV = vinLog.size(); bW = wrAddrLog.size();
    bF = fourthCycle.size(); bD = doneCount;
    applyStimulus();
    waitDone(bD, 2000, seen);
    checkOutput("rnd_doneSeen", 32'(seen), 1);
    checkPass("rnd", bC, bV, bW, bF);
    checkOutput("rnd_err", 32'(ifc.protocol_err), 0);
    randomMode = 1'b0;
    waitCycles(2);

    // Reset during the 10th WAIT
    $display("[TB] reset mid-pass");
    bC = convLog.size(); bD = doneCount;
    applyStimulus();
    waitConvReqs(bC + 10, 500, seen);
    checkOutput("mid_reached", 32'(seen), 1);
    reset = 1'b1;
    #1;
    checkAllZero("mid");
    waitCycles(3);
    reset = 1'b0;
    nWr = wrAddrLog.size();
    bC = convLog.size();
    waitCycles(10);
    checkOutput("mid_noWrite", 32'(wrAddrLog.size() - nWr), 0);
    checkOutput("mid_noReq", 32'(convLog.size() - bC), 0);
    checkOutput("mid_ndone", 32'(doneCount - bD), 0);
    bV = vinLog.size(); bW = wrAddrLog.size(); bF = fourthCycle.size(); bD = doneCount;
    applyStimulus();
    waitDone(bD, 1000, seen);
    checkOutput("restart_doneSeen", 32'(seen), 1);
    checkPass("restart", bC, bV, bW, bF);
    waitCycles(2);

    // Stray conv_done while idle
    $display("[TB] stray conv_done");
    bC = convLog.size();
    checkOutput("stray_errBefore", 32'(ifc.protocol_err), 0);
    injectConvDone = 1'b1;
    nextSample();
    injectConvDone = 1'b0;
    nextSample();
    checkOutput("stray_err", 32'(ifc.protocol_err), 1);
    waitCycles(5);
    checkOutput("stray_errSticky", 32'(ifc.protocol_err), 1);
    checkOutput("stray_noReq", 32'(convLog.size() - bC), 0);
    checkOutput("stray_idle", 32'(ifc.dut_busy), 0);

    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    nextSample();
    checkOutput("clr_err", 32'(ifc.protocol_err), 0);

    // Pool result with nothing pending
    $display("[TB] spurious pool output");
    nWr = wrAddrLog.size();
    injectPool = 1'b1;
    nextSample();
    injectPool = 1'b0;
    checkOutput("spur_vout", 32'(ifc.pool_valid_out), 1);
    checkOutput("spur_we", 32'(ifc.sram_we), 0);
    nextSample();
    checkOutput("spur_err", 32'(ifc.protocol_err), 1);
    checkOutput("spur_noWrite", 32'(wrAddrLog.size() - nWr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
